// File: rtl/data_mem_responder_pkg.sv
// Shared formats, FSM encoding and address helper for the data-memory responder.
package data_mem_responder_pkg;

  localparam logic [2:0] DATA_FORMAT_B  = 3'b000;
  localparam logic [2:0] DATA_FORMAT_H  = 3'b001;
  localparam logic [2:0] DATA_FORMAT_W  = 3'b010;
  localparam logic [2:0] DATA_FORMAT_BU = 3'b100;
  localparam logic [2:0] DATA_FORMAT_HU = 3'b101;

  typedef enum logic [1:0] {
    RSP_IDLE    = 2'b00,
    RSP_WAIT    = 2'b01,
    RSP_RESPOND = 2'b10
  } rsp_state_t;

  // Unsigned distance from the RAM base; addresses below the base wrap to huge values.
  function automatic logic [31:0] offset_from_base(input logic [31:0] address,
                                                   input logic [31:0] base);
    return address - base;
  endfunction

endpackage

// File: rtl/data_mem_lane_align.sv
// Byte-lane steering for stores, load extension, and alignment/format legality.
module data_mem_lane_align
  import data_mem_responder_pkg::*;
(
  input  logic [2:0]  data_format,
  input  logic        is_store,
  input  logic [1:0]  byte_offset,
  input  logic [31:0] write_data,
  input  logic [31:0] read_word,
  output logic [3:0]  byte_mask,
  output logic [31:0] store_word,
  output logic [31:0] load_value,
  output logic        bad_access
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Pick the addressed byte and half-word out of the raw RAM word.
  always_comb begin
    byte_s = 8'h00;
    case (byte_offset)
      2'b00:   byte_s = read_word[7:0];
      2'b01:   byte_s = read_word[15:8];
      2'b10:   byte_s = read_word[23:16];
      2'b11:   byte_s = read_word[31:24];
      default: byte_s = 8'h00;
    endcase
    half_s = byte_offset[1] ? read_word[31:16] : read_word[15:0];
  end

  // Store data is replicated across lanes so the byte mask alone selects what lands.
  always_comb begin
    byte_mask  = 4'b0000;
    store_word = 32'h0000_0000;
    load_value = 32'h0000_0000;
    bad_access = 1'b0;
    case (data_format)
      DATA_FORMAT_B: begin
        byte_mask  = 4'b0001 << byte_offset;
        store_word = {4{write_data[7:0]}};
        load_value = {{24{byte_s[7]}}, byte_s};
      end
      DATA_FORMAT_H: begin
        byte_mask  = byte_offset[1] ? 4'b1100 : 4'b0011;
        store_word = {2{write_data[15:0]}};
        load_value = {{16{half_s[15]}}, half_s};
        bad_access = byte_offset[0];
      end
      DATA_FORMAT_W: begin
        byte_mask  = 4'b1111;
        store_word = write_data;
        load_value = read_word;
        bad_access = |byte_offset;
      end
      DATA_FORMAT_BU: begin
        load_value = {24'h00_0000, byte_s};
        bad_access = is_store;
      end
      DATA_FORMAT_HU: begin
        load_value = {16'h0000, half_s};
        bad_access = is_store | byte_offset[0];
      end
      default: begin
        bad_access = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: word RAM served after a fixed number of wait states,
// with lane alignment, load extension and alignment/range error reporting.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS  = 1024,
  parameter logic [31:0] BASE_ADDRESS = 32'h8000_0000,
  parameter int unsigned WAIT_CYCLES  = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_read_enable,
  input  logic        req_write_enable,
  input  logic [31:0] req_address,
  input  logic [31:0] req_write_data,
  input  logic [2:0]  req_data_format,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_read_data,
  output logic        rsp_error
);

  localparam int unsigned INDEX_WIDTH  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] WINDOW_BYTES = 32'(DEPTH_WORDS * 4);
  localparam logic [3:0]  WAIT_LOAD    = 4'(WAIT_CYCLES);

  rsp_state_t state_r, state_next_s;
  logic [3:0]  wait_count_r, wait_count_next_s;
  logic        ready_r, valid_r, error_r;
  logic [31:0] read_data_r;

  logic        lat_read_r, lat_write_r;
  logic [31:0] lat_address_r, lat_write_data_r;
  logic [2:0]  lat_format_r;

  logic        accept_s, commit_s;
  logic        cur_read_s, cur_write_s;
  logic [31:0] cur_address_s, cur_write_data_s;
  logic [2:0]  cur_format_s;

  logic [31:0] offset_s;
  logic [INDEX_WIDTH-1:0] word_index_s;
  logic [31:0] read_word_s, store_word_s, load_value_s, resp_data_s;
  logic [3:0]  byte_mask_s;
  logic        align_bad_s, access_error_s, store_commit_s;

  logic [31:0] mem_r [DEPTH_WORDS];

  assign accept_s = ready_r & (req_read_enable | req_write_enable);
  // RESPOND always returns to IDLE, so entering it is exactly "next is RESPOND".
  assign commit_s = (state_next_s == RSP_RESPOND);

  // With no wait states the commit coincides with accept, so use the live request then.
  always_comb begin
    if (state_r == RSP_IDLE) begin
      cur_read_s       = req_read_enable;
      cur_write_s      = req_write_enable;
      cur_address_s    = req_address;
      cur_write_data_s = req_write_data;
      cur_format_s     = req_data_format;
    end else begin
      cur_read_s       = lat_read_r;
      cur_write_s      = lat_write_r;
      cur_address_s    = lat_address_r;
      cur_write_data_s = lat_write_data_r;
      cur_format_s     = lat_format_r;
    end
  end

  assign offset_s     = offset_from_base(cur_address_s, BASE_ADDRESS);
  assign word_index_s = offset_s[INDEX_WIDTH+1:2];
  assign read_word_s  = mem_r[word_index_s];

  data_mem_lane_align u_lane_align (
    .data_format (cur_format_s),
    .is_store    (cur_write_s),
    .byte_offset (cur_address_s[1:0]),
    .write_data  (cur_write_data_s),
    .read_word   (read_word_s),
    .byte_mask   (byte_mask_s),
    .store_word  (store_word_s),
    .load_value  (load_value_s),
    .bad_access  (align_bad_s)
  );

  // Error classification and the response word presented at commit.
  always_comb begin
    access_error_s = (cur_read_s & cur_write_s) | align_bad_s | (offset_s >= WINDOW_BYTES);
    if (access_error_s) begin
      resp_data_s = 32'h0000_0000;
    end else if (cur_read_s) begin
      resp_data_s = load_value_s;
    end else begin
      resp_data_s = 32'h0000_0000;
    end
    store_commit_s = commit_s & cur_write_s & ~access_error_s;
  end

  // Next-state and wait-counter logic.
  always_comb begin
    state_next_s      = state_r;
    wait_count_next_s = wait_count_r;
    case (state_r)
      RSP_IDLE: begin
        if (accept_s) begin
          wait_count_next_s = WAIT_LOAD;
          if (WAIT_CYCLES == 0) begin
            state_next_s = RSP_RESPOND;
          end else begin
            state_next_s = RSP_WAIT;
          end
        end else begin
          state_next_s = RSP_IDLE;
        end
      end
      RSP_WAIT: begin
        wait_count_next_s = wait_count_r - 4'd1;
        // <= guards against a corrupted zero count stalling for 15 extra cycles.
        if (wait_count_r <= 4'd1) begin
          state_next_s = RSP_RESPOND;
        end else begin
          state_next_s = RSP_WAIT;
        end
      end
      RSP_RESPOND: begin
        state_next_s      = RSP_IDLE;
        wait_count_next_s = 4'd0;
      end
      default: begin
        state_next_s      = RSP_IDLE;
        wait_count_next_s = 4'd0;
      end
    endcase
  end

  // Control state, registered outputs and request latches.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_r          <= RSP_IDLE;
      wait_count_r     <= 4'd0;
      ready_r          <= 1'b0;
      valid_r          <= 1'b0;
      read_data_r      <= 32'h0000_0000;
      error_r          <= 1'b0;
      lat_read_r       <= 1'b0;
      lat_write_r      <= 1'b0;
      lat_address_r    <= 32'h0000_0000;
      lat_write_data_r <= 32'h0000_0000;
      lat_format_r     <= 3'b000;
    end else begin
      state_r      <= state_next_s;
      wait_count_r <= wait_count_next_s;
      ready_r      <= (state_next_s == RSP_IDLE);
      valid_r      <= commit_s;
      if (commit_s) begin
        read_data_r <= resp_data_s;
        error_r     <= access_error_s;
      end else if (accept_s) begin
        read_data_r <= 32'h0000_0000;
        error_r     <= 1'b0;
      end else begin
        read_data_r <= read_data_r;
        error_r     <= error_r;
      end
      if (accept_s) begin
        lat_read_r       <= req_read_enable;
        lat_write_r      <= req_write_enable;
        lat_address_r    <= req_address;
        lat_write_data_r <= req_write_data;
        lat_format_r     <= req_data_format;
      end else begin
        lat_read_r       <= lat_read_r;
        lat_write_r      <= lat_write_r;
        lat_address_r    <= lat_address_r;
        lat_write_data_r <= lat_write_data_r;
        lat_format_r     <= lat_format_r;
      end
    end
  end

  // RAM write port; contents intentionally survive reset.
  always_ff @(posedge clock) begin
    if (reset_n && store_commit_s) begin
      for (int lane = 0; lane < 4; lane++) begin
        if (byte_mask_s[lane]) begin
          mem_r[word_index_s][8*lane +: 8] <= store_word_s[8*lane +: 8];
        end
      end
    end
  end

  assign req_ready     = ready_r;
  assign rsp_valid     = valid_r;
  assign rsp_read_data = read_data_r;
  assign rsp_error     = error_r;

endmodule
